// File: rtl/reg_file_2r1w.sv
// Architectural register file: DEPTH x WIDTH storage, one synchronous write
// port, two combinational read ports with write-to-read bypass, entry 0
// hardwired to zero, and a one-entry-per-cycle clear sequencer.
module reg_file_2r1w #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  input  logic             clr_req,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_reg;
  logic [AW-1:0]    ptr_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];

  // A write lands only in IDLE and never at entry 0; the same qualifier
  // gates the bypass so a dropped write is never visible on the read ports.
  logic write_ok;
  assign write_ok = (state_reg == IDLE) && we && (waddr != '0);

  // Clear sequencer: IDLE arms a sweep from entry 1; CLEAR walks ptr up to
  // DEPTH-1 and returns to IDLE on that last entry. clr_req is ignored in CLEAR.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clr_req) begin
            state_reg <= CLEAR;
            ptr_reg   <= AW'(1);
            busy_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          ptr_reg <= ptr_reg + AW'(1);
          if (ptr_reg == AW'(DEPTH - 1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;

  // Storage entries. Entry 0 is never written (write_ok excludes it and the
  // sweep starts at 1), so it holds the zero it gets at reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Per-entry update: reset clears, the sweep clears the pointed entry,
    // otherwise an accepted write to this address loads wdata.
    always_ff @(posedge clk) begin
      if (!rst) begin
        mem_reg[gi] <= '0;
      end else if ((state_reg == CLEAR) && (ptr_reg == AW'(gi))) begin
        mem_reg[gi] <= '0;
      end else if (write_ok && (waddr == AW'(gi))) begin
        mem_reg[gi] <= wdata;
      end
    end
  end

  // Read port 1: zero for address 0, bypassed write data when it targets the
  // same address this cycle, stored contents otherwise.
  always_comb begin
    rdata1 = mem_reg[raddr1];
    if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (write_ok && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
  end

  // Read port 2: identical selection, independent of port 1.
  always_comb begin
    rdata2 = mem_reg[raddr2];
    if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (write_ok && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed steps from the test plan
// followed by random traffic, all checked against a behavioural model.
module tb_reg_file_2r1w;

  localparam int W = 32;
  localparam int D = 32;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         we = 1'b0;
  logic [A-1:0] waddr = '0;
  logic [W-1:0] wdata = '0;
  logic [A-1:0] raddr1 = '0;
  logic [A-1:0] raddr2 = '0;
  logic [W-1:0] rdata1;
  logic [W-1:0] rdata2;
  logic         clr_req = 1'b0;
  logic         busy;

  reg_file_2r1w #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .clr_req(clr_req),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: contents, whether a sweep is running, and how many
  // sweep edges have happened so far (edge k zeroes entry k).
  logic [W-1:0] m_mem [D];
  logic         m_busy = 1'b0;
  int           m_step = 0;
  logic         m_valid = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int busy_seen = 0;

  function automatic logic [W-1:0] ref_read(input logic [A-1:0] a);
    if (a == 0) return '0;
    if (!m_busy && we && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, clock, update model.
  task automatic step(input logic r, input logic w, input logic [A-1:0] wa,
                      input logic [W-1:0] wd, input logic [A-1:0] a1,
                      input logic [A-1:0] a2, input logic c);
    rst = r; we = w; waddr = wa; wdata = wd;
    raddr1 = a1; raddr2 = a2; clr_req = c;
    #1;
    if (m_valid) begin
      check("rdata1", rdata1, ref_read(a1));
      check("rdata2", rdata2, ref_read(a2));
      check("busy", {31'b0, busy}, {31'b0, m_busy});
    end
    if (busy === 1'b1) busy_seen++;
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      m_busy = 1'b0;
      m_step = 0;
      m_valid = 1'b1;
    end else if (m_busy) begin
      m_step++;
      m_mem[m_step] = '0;
      if (m_step == D - 1) m_busy = 1'b0;
    end else begin
      if (w && wa != 0) m_mem[wa] = wd;
      if (c) begin
        m_busy = 1'b1;
        m_step = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_read(input logic [A-1:0] a1, input logic [A-1:0] a2);
    step(1'b1, 1'b0, '0, '0, a1, a2, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    // Reset for two cycles, then read every entry on both ports.
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    for (int a = 0; a < D; a++) idle_read(A'(a), A'(D - 1 - a));

    // Write with same-cycle bypass, then readback with we=0.
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd4, 1'b0);
    check("r5_bypass_const", m_mem[5], 32'hDEADBEEF);
    idle_read(5'd5, 5'd5);
    check("r5_readback_const", rdata1, 32'hDEADBEEF);

    // Entry 0 stays zero, no bypass for address 0.
    step(1'b1, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0);
    idle_read(5'd0, 5'd0);

    // Fill r1..r31, then pulse clr_req and watch the sweep.
    for (int k = 1; k < D; k++)
      step(1'b1, 1'b1, A'(k), W'(32'h100 + k), A'(k), A'(k - 1), 1'b0);
    busy_seen = 0;
    step(1'b1, 1'b0, '0, '0, 5'd10, 5'd11, 1'b1);
    for (int i = 0; i < D - 1; i++) begin
      if (i == 10) begin
        check("r10_after_10_edges", rdata1, 32'h0);
        check("r11_after_10_edges", rdata2, 32'h10B);
      end
      if (i == 5) step(1'b1, 1'b1, 5'd31, 32'hAAAA, 5'd10, 5'd31, 1'b0);
      else        step(1'b1, 1'b0, '0, '0, 5'd10, 5'd11, 1'b0);
    end
    idle_read(5'd31, 5'd1);
    check("busy_high_cycles", W'(busy_seen), W'(D - 1));
    check("r31_after_sweep", rdata1, 32'h0);
    for (int a = 0; a < D; a++) idle_read(A'(a), A'(D - 1 - a));

    // First write after the sweep is accepted.
    step(1'b1, 1'b1, 5'd31, 32'hAAAA, 5'd31, 5'd30, 1'b0);
    idle_read(5'd31, 5'd31);
    check("r31_post_clear_write", rdata2, 32'hAAAA);

    // Reset in the middle of a sweep, then a write to r3.
    for (int k = 1; k < D; k++)
      step(1'b1, 1'b1, A'(k), W'($urandom), A'(k), A'($urandom), 1'b0);
    step(1'b1, 1'b0, '0, '0, 5'd1, 5'd20, 1'b1);
    for (int i = 0; i < 6; i++) idle_read(A'(i + 1), 5'd20);
    step(1'b0, 1'b1, 5'd25, 32'h5555, 5'd20, 5'd25, 1'b0);
    check("busy_after_reset", {31'b0, busy}, 32'h0);
    step(1'b1, 1'b1, 5'd3, 32'h33333333, 5'd3, 5'd20, 1'b0);
    idle_read(5'd3, 5'd25);
    check("r3_after_reset", rdata1, 32'h33333333);
    for (int a = 0; a < D; a++) idle_read(A'(a), A'($urandom));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) != 0), $urandom_range(0, 1) == 1,
           A'($urandom), W'($urandom), A'($urandom), A'($urandom),
           $urandom_range(0, 24) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
